serial_mag_comparator: RTL and testbench

Bit-serial, MSB-first magnitude comparator for two WIDTH-bit unsigned words, for links where both operands arrive one bit per cycle. It applies the 1-bit greater/equal/less rule to each incoming bit pair. The first unequal bit locks the verdict, and all later bits are ignored. It returns the registered g/e/l flags and a one-cycle done pulse once all WIDTH bits have been consumed.

---
 rtl/serial_mag_comparator.sv | 106 ++++++++++
 tb/tb_serial_mag_comparator.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/serial_mag_comparator.sv
// Bit-serial MSB-first magnitude comparator: consumes one (a,b) bit pair per
// valid&ready cycle and locks the g/e/l verdict at the first unequal pair.
module serial_mag_comparator #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic a,
  input  logic b,
  input  logic valid,
  output logic ready,
  output logic busy,
  output logic decided,
  output logic g,
  output logic e,
  output logic l,
  output logic done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          g_n, e_n, l_n, decided_n, done_n;
  logic          last_bit;

  assign last_bit = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      g       <= 1'b0;
      e       <= 1'b0;
      l       <= 1'b0;
      decided <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      g       <= g_n;
      e       <= e_n;
      l       <= l_n;
      decided <= decided_n;
      done    <= done_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    g_n       = g;
    e_n       = e;
    l_n       = l;
    decided_n = decided;
    done_n    = 1'b0;
    case (state)
      S_IDLE: begin
        // valid is deliberately ignored here, even alongside start
        if (start) begin
          state_n   = S_SHIFT;
          cnt_n     = '0;
          g_n       = 1'b0;
          e_n       = 1'b1;
          l_n       = 1'b0;
          decided_n = 1'b0;
        end
      end
      S_SHIFT: begin
        if (valid) begin
          cnt_n = last_bit ? '0 : cnt + CW'(1);
          // once decided, later (less significant) bits cannot change the verdict
          if (!decided) begin
            g_n       = a & ~b;
            l_n       = ~a & b;
            e_n       = ~(a ^ b);
            decided_n = a ^ b;
          end
          if (last_bit) begin
            state_n = S_DONE;
            done_n  = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Handshake: a pair transfers only when valid && ready; ready is high
  // exactly in SHIFT, and the source holds a/b while valid && !ready.
  assign ready = (state == S_SHIFT);
  assign busy  = (state != S_IDLE);

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Bench for serial_mag_comparator: table of words plus hand sequences for
// reset mid-word; a queue of expected final verdicts is checked on each done.
module tb_serial_mag_comparator;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst, start, a, b, valid;
  logic ready, busy, decided, g, e, l, done;

  int checks = 0;
  int errors = 0;
  logic [2:0] exp_q[$];
  logic [2:0] sb_exp;

  typedef struct {
    logic [W-1:0] aw;
    logic [W-1:0] bw;
    int           stalls;
    bit           collide;
    logic [2:0]   gel;
  } vec_t;

  vec_t vecs[7];

  serial_mag_comparator #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .valid(valid),
    .ready(ready), .busy(busy), .decided(decided),
    .g(g), .e(e), .l(l), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every done pulse pops the verdict queued at start
  always @(negedge clk) begin
    if (!rst && done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_done actual=%0b required=none", {g, e, l});
      end else begin
        sb_exp = exp_q.pop_front();
        if ({g, e, l} !== sb_exp) begin
          errors++;
          $display("FAIL sb_verdict actual=%0b required=%0b", {g, e, l}, sb_exp);
        end
      end
    end
  end

  task automatic run_word(input logic [W-1:0] aw, input logic [W-1:0] bw,
                          input int stalls, input bit collide, input logic [2:0] gel);
    int n_edges;
    int stalls_left;
    logic [W-1:0] pa, pb;
    // start cycle; with collide the pair (1,0) is offered and must be ignored
    @(posedge clk); #1;
    start = 1'b1; valid = collide; a = 1'b1; b = 1'b0;
    exp_q.push_back(gel);
    @(posedge clk); #1;
    start = 1'b0; valid = 1'b0;
    n_edges = 0;
    check("load_state", {ready, busy, g, e, l, decided}, 6'b110100);
    stalls_left = stalls;
    for (int j = 0; j < W; j++) begin
      if (j > 0) begin
        while (stalls_left > 0 && ($urandom_range(0, 1) == 1 || stalls_left >= W - j)) begin
          valid = 1'b0; a = 1'($urandom_range(0, 1)); b = 1'($urandom_range(0, 1));
          start = 1'b1;
          @(posedge clk); #1;
          start = 1'b0;
          n_edges++;
          stalls_left--;
          pa = aw >> (W - j);
          pb = bw >> (W - j);
          check("stall_hold", {ready, g, e, l, decided}, {1'b1, pa > pb, pa == pb, pa < pb, pa != pb});
        end
      end
      valid = 1'b1; a = aw[W-1-j]; b = bw[W-1-j];
      @(posedge clk); #1;
      valid = 1'b0;
      n_edges++;
      pa = aw >> (W - 1 - j);
      pb = bw >> (W - 1 - j);
      check("step_flags", {ready, g, e, l, decided}, {j < W - 1, pa > pb, pa == pb, pa < pb, pa != pb});
      check("onehot", $countones({g, e, l}), 1);
    end
    check("done_latency", n_edges, W + stalls);
    check("done_cycle", {done, ready, busy, g, e, l}, {3'b101, gel});
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("idle_after_done", {done, ready, busy}, 3'b000);
    check("hold_idle", {g, e, l}, gel);
    @(posedge clk); #1;
    check("hold_idle2", {done, busy, g, e, l}, {2'b00, gel});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] ra, rb;
    vecs[0] = '{8'hA5, 8'hA5, 0, 1'b0, 3'b010};
    vecs[1] = '{8'h80, 8'h7F, 0, 1'b0, 3'b100};
    vecs[2] = '{8'h3C, 8'h3D, 0, 1'b0, 3'b001};
    vecs[3] = '{8'h0F, 8'h0E, 3, 1'b0, 3'b100};
    vecs[4] = '{8'h55, 8'h55, 0, 1'b1, 3'b010};
    vecs[5] = '{8'h00, 8'hFF, 2, 1'b1, 3'b001};
    vecs[6] = '{8'hFF, 8'hFE, 0, 1'b0, 3'b100};

    rst = 1'b1; start = 1'b0; a = 1'b0; b = 1'b0; valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {ready, busy, decided, g, e, l, done}, 7'b0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++)
      run_word(vecs[i].aw, vecs[i].bw, vecs[i].stalls, vecs[i].collide, vecs[i].gel);

    // Reset after four consumed bits abandons the word
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int j = 0; j < 4; j++) begin
      valid = 1'b1; a = 1'b1; b = 1'(j[0]);
      @(posedge clk); #1;
    end
    valid = 1'b0;
    check("midword_busy", {busy, ready, g, decided}, 4'b1111);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midword_reset", {g, e, l, done, ready, busy, decided}, 7'b0);
    run_word(8'h01, 8'h02, 0, 1'b0, 3'b001);

    for (int i = 0; i < 6; i++) begin
      ra = W'($urandom);
      rb = (i % 3 == 0) ? ra : W'($urandom);
      run_word(ra, rb, $urandom_range(0, 2), 1'($urandom_range(0, 1)),
               {ra > rb, ra == rb, ra < rb});
    end

    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
